// File: rtl/freq_bcd_conv_if.sv
// Handshake and result bundle between the frequency calculator, the BCD
// converter and the display driver.
interface freq_bcd_conv_if #(
   parameter int DATA_W = 20,
   parameter int DIGITS = 6
);
   logic [DATA_W-1:0]   data_in;
   logic                data_valid;
   logic [4*DIGITS-1:0] bcd_out;
   logic [DIGITS-1:0]   blank;
   logic                bcd_valid;
   logic                busy;
   logic                sat_flag;
   logic                overrun;

   modport master (
      output data_in, data_valid,
      input  bcd_out, blank, bcd_valid, busy, sat_flag, overrun
   );

   modport slave (
      input  data_in, data_valid,
      output bcd_out, blank, bcd_valid, busy, sat_flag, overrun
   );
endinterface

// File: rtl/freq_bcd_conv.sv
// Sequential binary-to-BCD converter: saturates the frequency to the display
// range and runs double-dabble one bit per clock, with a leading-zero mask.
module freq_bcd_conv #(
   parameter int DATA_W  = 20,
   parameter int DIGITS  = 6,
   parameter int MAX_VAL = 999_999
) (
   input  logic           sys_clk,
   input  logic           sys_rst_n,
   freq_bcd_conv_if.slave bus
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [DATA_W-1:0]   MAX_V      = DATA_W'(MAX_VAL);
   localparam logic [CNT_W-1:0]    LAST_CNT   = CNT_W'(DATA_W - 1);
   localparam logic [DIGITS-1:0]   BLANK_RST  = {{(DIGITS-1){1'b1}}, 1'b0};

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t                state_r;
   state_t                state_nxt_s;
   logic [CNT_W-1:0]      cnt_r;
   logic [DATA_W-1:0]     bin_r;
   logic [4*DIGITS-1:0]   scratch_r;
   logic [4*DIGITS-1:0]   bcd_out_r;
   logic [DIGITS-1:0]     blank_r;
   logic                  bcd_valid_r;
   logic                  busy_r;
   logic                  sat_flag_r;
   logic                  overrun_r;

   logic                  accept_s;
   logic                  shift_s;
   logic                  done_s;
   logic                  overrun_s;
   logic                  over_s;
   logic [DATA_W-1:0]     sat_val_s;
   logic [4*DIGITS-1:0]   fixed_s;
   logic [4*DIGITS+DATA_W-1:0] shifted_s;

   // Add-3 correction: any digit >= 5 gets +3 so the next shift carries correctly.
   function automatic logic [4*DIGITS-1:0] dabble_fix(input logic [4*DIGITS-1:0] s);
      logic [4*DIGITS-1:0] r;
      r = s;
      for (int i = 0; i < DIGITS; i++) begin
         if (s[4*i +: 4] >= 4'd5) begin
            r[4*i +: 4] = s[4*i +: 4] + 4'd3;
         end else begin
            r[4*i +: 4] = s[4*i +: 4];
         end
      end
      return r;
   endfunction

   // Digit i (i >= 1) is blanked when it and every higher digit are zero.
   function automatic logic [DIGITS-1:0] blank_of(input logic [4*DIGITS-1:0] d);
      logic [DIGITS-1:0] r;
      logic              zero_run;
      r        = '0;
      zero_run = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         zero_run = zero_run & (d[4*i +: 4] == 4'd0);
         r[i]     = zero_run;
      end
      return r;
   endfunction

   assign over_s    = (bus.data_in > MAX_V);
   assign sat_val_s = over_s ? MAX_V : bus.data_in;
   assign fixed_s   = dabble_fix(scratch_r);
   assign shifted_s = {fixed_s, bin_r} << 1;

   // State register.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state and per-cycle control strobes.
   always_comb begin
      state_nxt_s = state_r;
      accept_s    = 1'b0;
      shift_s     = 1'b0;
      done_s      = 1'b0;
      overrun_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (bus.data_valid) begin
               accept_s    = 1'b1;
               state_nxt_s = ST_SHIFT;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            shift_s   = 1'b1;
            overrun_s = bus.data_valid;
            if (cnt_r == LAST_CNT) begin
               done_s      = 1'b1;
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_SHIFT;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Conversion datapath and registered outputs.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         cnt_r       <= '0;
         bin_r       <= '0;
         scratch_r   <= '0;
         bcd_out_r   <= '0;
         blank_r     <= BLANK_RST;
         bcd_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         sat_flag_r  <= 1'b0;
         overrun_r   <= 1'b0;
      end else begin
         bcd_valid_r <= done_s;
         overrun_r   <= overrun_s;
         if (accept_s) begin
            bin_r      <= sat_val_s;
            scratch_r  <= '0;
            cnt_r      <= '0;
            sat_flag_r <= over_s;
            busy_r     <= 1'b1;
         end else if (shift_s) begin
            scratch_r <= shifted_s[4*DIGITS+DATA_W-1:DATA_W];
            bin_r     <= shifted_s[DATA_W-1:0];
            cnt_r     <= cnt_r + CNT_W'(1);
            if (done_s) begin
               bcd_out_r <= shifted_s[4*DIGITS+DATA_W-1:DATA_W];
               blank_r   <= blank_of(shifted_s[4*DIGITS+DATA_W-1:DATA_W]);
               busy_r    <= 1'b0;
            end
         end
      end
   end

   assign bus.bcd_out   = bcd_out_r;
   assign bus.blank     = blank_r;
   assign bus.bcd_valid = bcd_valid_r;
   assign bus.busy      = busy_r;
   assign bus.sat_flag  = sat_flag_r;
   assign bus.overrun   = overrun_r;

endmodule
